// File: rtl/input_selector_ctrl_if.sv
// Config-side handshake bundle for input_selector_ctrl.
// Host drives writes/commits; controller returns status and active selectors.
interface input_selector_ctrl_if #(
  parameter int IDX_W = 4,
  parameter int ENT_W = 11,
  parameter int N_ENT = 16
);
  logic                   wWrEn;
  logic [IDX_W-1:0]       wWrIdx;
  logic [ENT_W-1:0]       wWrData;
  logic                   wWrReady;
  logic                   wCommit;
  logic                   wCommitReady;
  logic                   wPending;
  logic                   wBusy;
  logic                   wDone;
  logic [N_ENT*ENT_W-1:0] wSelec;

  modport master (
    output wWrEn, wWrIdx, wWrData, wCommit,
    input  wWrReady, wCommitReady, wPending,
    input  wBusy, wDone, wSelec
  );

  modport slave (
    input  wWrEn, wWrIdx, wWrData, wCommit,
    output wWrReady, wCommitReady, wPending,
    output wBusy, wDone, wSelec
  );
endinterface

// File: rtl/input_selector_ctrl.sv
// Shadow/active selector table with a busy-framed commit sequence
// (quiesce, swap, settle) for input_selector_block.
module input_selector_ctrl #(
  parameter int MAIN_INPUTS     = 16,
  parameter int REGS_INPUTS     = 64,
  parameter int OUTPUTS         = 4,
  parameter int OUTPUTS_PER_BUS = 4,
  parameter int QUIESCE_CYCLES  = 2,
  parameter int SETTLE_CYCLES   = 2
) (
  input logic                  clk,
  input logic                  reset_L,
  input_selector_ctrl_if.slave bus
);
  localparam int N_ENT = OUTPUTS * OUTPUTS_PER_BUS;
  localparam int ENT_W = $clog2(MAIN_INPUTS)
                       + $clog2(REGS_INPUTS) + 1;
  localparam int CMAX  = (QUIESCE_CYCLES > SETTLE_CYCLES)
                       ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUIESCE,
    S_SWAP,
    S_SETTLE
  } state_e;

  typedef logic [N_ENT-1:0][ENT_W-1:0] tbl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tbl_t             shadow_q, shadow_d;
  tbl_t             active_q, active_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic wr_rdy, cm_rdy, wr_fire, cm_fire;

  assign wr_rdy  = (state_q != S_SWAP);
  assign cm_rdy  = (state_q == S_IDLE);
  assign wr_fire = bus.wWrEn && wr_rdy;
  assign cm_fire = bus.wCommit && cm_rdy;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    done_d   = 1'b0;

    if (wr_fire) begin
      shadow_d[bus.wWrIdx] = bus.wWrData;
      pend_d               = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // a same-cycle write counts as pending for this commit
        if (cm_fire) begin
          if (pend_q || wr_fire) begin
            state_d = S_QUIESCE;
            cnt_d   = CNT_W'(QUIESCE_CYCLES - 1);
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_QUIESCE: begin
        if (cnt_q == '0) state_d = S_SWAP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SWAP: begin
        active_d = shadow_q;
        pend_d   = 1'b0;
        if (SETTLE_CYCLES == 0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.wWrReady     = wr_rdy;
  assign bus.wCommitReady = cm_rdy;
  assign bus.wPending     = pend_q;
  assign bus.wBusy        = busy_q;
  assign bus.wDone        = done_q;
  assign bus.wSelec       = active_q;
endmodule
